// File: rtl/tx_gearbox_66b.sv
// 66b -> OW-bit transmit gearbox. Blocks of {Pay_i, Hdr_i} are appended
// LSB-first into a bit buffer. One OW-bit word is popped from the bottom
// whenever enough bits are held. A new block is only accepted when it fits
// above the post-pop occupancy, so the buffer can never overflow.
module tx_gearbox_66b #(
  parameter int OW   = 32,
  parameter int BW   = 128,
  parameter int CNTW = 8
) (
  input  logic          Ck,
  input  logic          Rs,
  input  logic          CE,
  input  logic [1:0]    Hdr_i,
  input  logic [63:0]   Pay_i,
  input  logic          Blk_Vld_i,
  output logic          Blk_Rdy_o,
  output logic [OW-1:0] Dat_o,
  output logic          Dat_Vld_o
);

  localparam logic [CNTW-1:0] OW_C    = CNTW'(OW);
  localparam logic [CNTW-1:0] BLK_C   = CNTW'(66);
  localparam logic [CNTW:0]   BLK_W_C = (CNTW+1)'(66);
  localparam logic [CNTW:0]   BW_C    = (CNTW+1)'(BW);

  logic [BW-1:0]   buf_q, buf_d, blk_ext;
  logic [CNTW-1:0] cnt_q, cnt_d, cp;
  logic [OW-1:0]   dat_q;
  logic            dvld_q;
  logic            pop, room, acc;

  // Pop decision, post-pop occupancy and room check for a full block.
  // The room sum is one bit wider than the counter so it cannot wrap.
  always_comb begin
    pop  = (cnt_q >= OW_C);
    cp   = pop ? (cnt_q - OW_C) : cnt_q;
    room = (({1'b0, cp} + BLK_W_C) <= BW_C);
  end

  assign Blk_Rdy_o = CE & ~Rs & room;
  assign acc       = Blk_Vld_i & Blk_Rdy_o;

  // Next buffer/count: shift out the popped word, then place the new block
  // directly above the bits that remain.
  always_comb begin
    blk_ext = {{(BW-66){1'b0}}, Pay_i, Hdr_i};
    buf_d   = (pop ? (buf_q >> OW) : buf_q) | (acc ? (blk_ext << cp) : '0);
    cnt_d   = cp + (acc ? BLK_C : '0);
  end

  // State update; CE low freezes everything except the valid strobe.
  always_ff @(posedge Ck) begin
    if (Rs) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      dat_q  <= '0;
      dvld_q <= 1'b0;
    end else if (CE) begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      if (pop) dat_q <= buf_q[OW-1:0];
      dvld_q <= pop;
    end else begin
      dvld_q <= 1'b0;
    end
  end

  assign Dat_o     = dat_q;
  assign Dat_Vld_o = dvld_q;

endmodule

// File: tb/tb_tx_gearbox_66b.sv
// Bench for tx_gearbox_66b (OW=32): a directed vector table for reset and a
// single block, then streamed sequences checked against a bit-queue model.
module tb_tx_gearbox_66b;

  logic        Ck = 1'b0;
  logic        Rs, CE, Blk_Vld_i;
  logic [1:0]  Hdr_i;
  logic [63:0] Pay_i;
  logic        Blk_Rdy_o, Dat_Vld_o;
  logic [31:0] Dat_o;

  tx_gearbox_66b #(.OW(32), .BW(128), .CNTW(8)) dut (
    .Ck(Ck), .Rs(Rs), .CE(CE), .Hdr_i(Hdr_i), .Pay_i(Pay_i),
    .Blk_Vld_i(Blk_Vld_i), .Blk_Rdy_o(Blk_Rdy_o),
    .Dat_o(Dat_o), .Dat_Vld_o(Dat_Vld_o)
  );

  always #5 Ck = ~Ck;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: queue of bits waiting to go out, oldest at the front.
  logic        q[$];
  logic        m_vld = 1'b0;
  logic [31:0] m_dat = '0;
  logic        last_acc;
  logic        outq[$];   // bits actually seen on Dat_o during a run

  task automatic step(input logic rs, input logic ce, input logic vld,
                      input logic [1:0] hdr, input logic [63:0] pay);
    logic        pop, er;
    int          cp;
    logic [31:0] w;
    @(negedge Ck);
    Rs = rs; CE = ce; Blk_Vld_i = vld; Hdr_i = hdr; Pay_i = pay;
    pop = (q.size() >= 32);
    cp  = q.size() - (pop ? 32 : 0);
    er  = !rs && ce && (cp + 66 <= 128);
    #1 chk("blk_rdy", 64'(Blk_Rdy_o), 64'(er));
    last_acc = vld & er;
    if (rs) begin
      q.delete(); m_vld = 1'b0; m_dat = '0;
    end else if (ce) begin
      if (pop) begin
        for (int i = 0; i < 32; i++) w[i] = q.pop_front();
        m_dat = w;
      end
      m_vld = pop;
      if (last_acc) begin
        for (int i = 0; i < 2; i++)  q.push_back(hdr[i]);
        for (int i = 0; i < 64; i++) q.push_back(pay[i]);
      end
    end else begin
      m_vld = 1'b0;
    end
    @(posedge Ck); #1;
    chk("dat_vld", 64'(Dat_Vld_o), 64'(m_vld));
    chk("dat", 64'(Dat_o), 64'(m_dat));
    if (Dat_Vld_o) for (int i = 0; i < 32; i++) outq.push_back(Dat_o[i]);
  endtask

  typedef struct {
    logic        rs, ce, vld;
    logic [1:0]  hdr;
    logic [63:0] pay;
    logic        rdy, dvld;
    logic [31:0] dat;
  } vec_t;

  vec_t        tv[8];
  logic [1:0]  blk_h[200];
  logic [63:0] blk_p[200];
  logic        ref_bits[$];
  logic        acc_log[600];

  initial begin
    int idx, cyc, sum, bad, drops;
    logic [63:0] pay_r;

    Rs = 1'b1; CE = 1'b1; Blk_Vld_i = 1'b0; Hdr_i = '0; Pay_i = '0;

    // ---- directed table: reset, one block, underflow residue, CE low ----
    tv[0] = '{1, 1, 1, 2'b01, 64'h0123456789ABCDEF, 0, 0, 32'h0};
    tv[1] = '{1, 1, 1, 2'b01, 64'h0123456789ABCDEF, 0, 0, 32'h0};
    tv[2] = '{1, 1, 1, 2'b01, 64'h0123456789ABCDEF, 0, 0, 32'h0};
    tv[3] = '{0, 1, 1, 2'b01, 64'h0123456789ABCDEF, 1, 0, 32'h0};
    tv[4] = '{0, 1, 0, 2'b00, 64'h0,                1, 1, 32'h26AF37BD};
    tv[5] = '{0, 1, 0, 2'b00, 64'h0,                1, 1, 32'h048D159E};
    tv[6] = '{0, 1, 0, 2'b00, 64'h0,                1, 0, 32'h048D159E};
    tv[7] = '{0, 0, 1, 2'b11, 64'hFFFF0000FFFF0000, 0, 0, 32'h048D159E};
    for (int i = 0; i < 8; i++) begin
      @(negedge Ck);
      Rs = tv[i].rs; CE = tv[i].ce; Blk_Vld_i = tv[i].vld;
      Hdr_i = tv[i].hdr; Pay_i = tv[i].pay;
      #1 chk($sformatf("tv%0d_rdy", i), 64'(Blk_Rdy_o), 64'(tv[i].rdy));
      @(posedge Ck); #1;
      chk($sformatf("tv%0d_vld", i), 64'(Dat_Vld_o), 64'(tv[i].dvld));
      chk($sformatf("tv%0d_dat", i), 64'(Dat_o), 64'(tv[i].dat));
    end

    for (int i = 0; i < 200; i++) begin
      blk_h[i] = 2'($urandom_range(1, 2));
      blk_p[i] = {$urandom, $urandom};
    end

    // ---- continuous stream, CE=1 ----
    step(1, 1, 0, 2'b00, 64'h0);
    outq.delete();
    idx = 0; cyc = 0;
    while (idx < 200 && cyc < 600) begin
      step(0, 1, 1, blk_h[idx], blk_p[idx]);
      acc_log[cyc] = last_acc;
      if (last_acc) idx++;
      cyc++;
    end
    chk("stream_done", 64'(idx), 64'd200);
    for (int s = 10; s + 33 <= cyc; s += 33) begin
      sum = 0;
      for (int k = s; k < s + 33; k++) sum += int'(acc_log[k]);
      chk("accepts_per_33", 64'(sum), 64'd16);
    end
    ref_bits = outq;

    // ---- same blocks with CE toggling every cycle ----
    step(1, 1, 0, 2'b00, 64'h0);
    outq.delete();
    idx = 0;
    for (int c = 0; c < 120; c++) begin
      step(0, (c % 2) == 0, 1, blk_h[idx], blk_p[idx]);
      if (last_acc) idx++;
    end
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (i >= outq.size() || outq[i] !== ref_bits[i]) bad++;
    chk("ce_bitstream", 64'(bad), 64'd0);

    // ---- upstream gap of 5 cycles mid-stream ----
    step(1, 1, 0, 2'b00, 64'h0);
    outq.delete();
    idx = 0; cyc = 0;
    while (idx < 30 && cyc < 200) begin
      step(0, 1, 1, blk_h[idx], blk_p[idx]);
      if (last_acc) idx++;
      cyc++;
    end
    drops = 0;
    for (int g = 0; g < 5; g++) begin
      step(0, 1, 0, 2'b00, 64'h0);
      if (!Dat_Vld_o) drops++;
    end
    chk("gap_vld_dropped", 64'(drops > 0), 64'd1);
    cyc = 0;
    while (idx < 50 && cyc < 200) begin
      step(0, 1, 1, blk_h[idx], blk_p[idx]);
      if (last_acc) idx++;
      cyc++;
    end
    chk("gap_resume", 64'(idx), 64'd50);
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (i >= outq.size() || outq[i] !== ref_bits[i]) bad++;
    chk("gap_bitstream", 64'(bad), 64'd0);

    // ---- reset with 40 bits buffered ----
    // occupancy: 66,34,2 / 68,36,4 / 70,38,6 / 72,40
    step(1, 1, 0, 2'b00, 64'h0);
    for (int r = 0; r < 3; r++) begin
      step(0, 1, 1, blk_h[r], blk_p[r]);
      step(0, 1, 0, 2'b00, 64'h0);
      step(0, 1, 0, 2'b00, 64'h0);
    end
    step(0, 1, 1, blk_h[3], blk_p[3]);
    step(0, 1, 0, 2'b00, 64'h0);
    chk("pre_reset_fill", 64'(q.size()), 64'd40);
    step(1, 1, 1, 2'b11, 64'hDEADBEEF_DEADBEEF);
    chk("rst_mid_vld", 64'(Dat_Vld_o), 64'd0);
    pay_r = 64'hA5A5_0F0F_3C3C_5AB4;
    step(0, 1, 1, 2'b10, pay_r);
    step(0, 1, 0, 2'b00, 64'h0);
    chk("post_rst_word", 64'(Dat_o), 64'({pay_r[29:0], 2'b10}));
    chk("post_rst_first_bit", 64'(Dat_o[0]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
